b01_scan_test_ctrl: RTL and testbench
=====================================

// Module: b01_scan_test_ctrl
// PURPOSE
//  Scan-test sequencer for the full-scan b01 core (chain stato[0..2], outp, overflw; test_se/test_si/test_so).
//  Takes test patterns over a valid/ready interface and drives shift and capture on the core.
//  Unload of pattern k overlaps load of k+1. Compares the unloaded scan state and the captured POs
//  against expected values, then reports a per-pattern pass/fail and a running fail count.
// PARAMETERS
//  CHAIN_LEN  5   scan flops in core chain (>=2)
//  PI_W       2   core primary inputs (line1, line2)
//  PO_W       2   core primary outputs (outp, overflw)
//  CNT_W      16  width of pattern index and fail counter
// PORTS
//  clock      in   1          single clock, all state rising-edge
//  reset      in   1          asynchronous, active-high
//  pat_valid  in   1          pattern offered
//  pat_ready  out  1          controller accepts pattern
//  pat_scan   in   CHAIN_LEN  scan load; bit i shifted on shift cycle i
//  pat_pi     in   PI_W       PI values applied during shift and capture
//  pat_exp    in   CHAIN_LEN  expected post-capture scan state; bit i seen on test_so at unload cycle i
//  pat_exp_po in   PO_W       expected core_po at capture cycle
//  pat_last   in   1          final pattern of session
//  test_se    out  1          scan enable to core
//  test_si    out  1          scan data to core
//  test_so    in   1          scan data from core
//  core_pi    out  PI_W       core PIs
//  core_po    in   PO_W       core POs
//  res_valid  out  1          one-cycle result strobe
//  res_fail   out  1          result mismatch (valid with res_valid)
//  res_index  out  CNT_W      index of reported pattern (first pattern = 0)
//  fail_count out  CNT_W      failing patterns this session, saturating
//  done       out  1          one-cycle pulse after the last result
// BEHAVIOUR
//  Reset: state IDLE. test_se=0, test_si=0, core_pi=0. All res_*, fail_count and done = 0.
//   Pending result, index and pattern registers cleared. Reset mid-operation aborts with no result.
//  pat_ready = (state==IDLE || state==WAIT). Transfer = pat_valid & pat_ready, not during reset.
//   On transfer, all pat_* fields are latched.
//  States:
//   IDLE->SHIFT on transfer. Clears fail_count, sets next index 0, clears have_prev.
//   SHIFT: CHAIN_LEN cycles, cnt 0..CHAIN_LEN-1.
//    test_se=1, test_si=scan[cnt], core_pi=pi.
//    If have_prev: test_so sampled each cycle, XOR prev_exp[cnt] accumulated into mismatch.
//    cnt==CHAIN_LEN-1 -> CAPTURE.
//   CAPTURE: exactly 1 cycle, test_se=0, core_pi=pi.
//    po_mis <= |(core_po ^ exp_po) for the current pattern.
//    If have_prev: res_valid=1, res_fail = scan mismatch | prev po_mis, res_index = prev index.
//    Current exp/po_mis/index become prev; have_prev=1.
//    Next state: UNLOAD if last, else WAIT.
//   WAIT: test_se=0, core_pi holds. Core clock keeps running; pattern integrity is the source's concern.
//    Transfer -> SHIFT.
//   UNLOAD: CHAIN_LEN cycles, test_se=1, test_si=0, compare as in SHIFT.
//    Then 1 cycle REPORT: res_valid for final pattern, done=1 -> IDLE.
//  fail_count increments on res_valid&res_fail. Holds at 2^CNT_W-1. Updated the cycle after the strobe.
//  fail_count and res_index hold after done until the next session's first transfer.
//  Index wraps at 2^CNT_W. Latency pattern k transfer -> its result: 2*CHAIN_LEN+2 cycles min.
//  res_index, res_fail registered; stable only while res_valid=1.
// TESTING
//  1 pattern, last=1, core model matching exp -> 5 SHIFT, 1 CAPTURE, 5 UNLOAD; res_valid index0 fail0; done; fail_count=0
//  3 back-to-back patterns, pat_valid held high -> pat_ready only in WAIT; results idx0,1,2 all pass; gap SHIFT->SHIFT = 7 cycles
//  pattern1 exp bit 3 flipped -> res_fail=1 on idx1 only; fail_count=1 after done
//  exp_po mismatch on capture of pattern0 with scan matching -> idx0 res_fail=1
//  reset asserted mid-SHIFT cnt=2 -> test_se=0 immediately, no res_valid; next session starts at index 0, fail_count=0
//  CNT_W=2, 5 failing patterns -> fail_count saturates at 3; res_index sequence 0,1,2,3,0

Source files
------------

// File: rtl/b01_scan_test_ctrl_if.sv
// Pattern-in / result-out bundle between a scan pattern source and b01_scan_test_ctrl.
// master = pattern source and result sink, slave = the controller.
interface b01_scan_test_ctrl_if #(
  parameter int CHAIN_LEN = 5,
  parameter int PI_W      = 2,
  parameter int PO_W      = 2,
  parameter int CNT_W     = 16
);
  logic                 pat_valid;
  logic                 pat_ready;
  logic [CHAIN_LEN-1:0] pat_scan;
  logic [PI_W-1:0]      pat_pi;
  logic [CHAIN_LEN-1:0] pat_exp;
  logic [PO_W-1:0]      pat_exp_po;
  logic                 pat_last;
  logic                 res_valid;
  logic                 res_fail;
  logic [CNT_W-1:0]     res_index;
  logic [CNT_W-1:0]     fail_count;
  logic                 done;

  modport master (
    output pat_valid, pat_scan, pat_pi, pat_exp, pat_exp_po, pat_last,
    input  pat_ready, res_valid, res_fail, res_index, fail_count, done
  );

  modport slave (
    input  pat_valid, pat_scan, pat_pi, pat_exp, pat_exp_po, pat_last,
    output pat_ready, res_valid, res_fail, res_index, fail_count, done
  );
endinterface

// File: rtl/b01_scan_test_ctrl.sv
// Scan-test sequencer for the b01 core: shift/capture per pattern, unload of k overlapped with load of k+1.
// Result for a pattern arrives >= 2*CHAIN_LEN+2 cycles after its transfer; patterns accepted only in IDLE/WAIT.
module b01_scan_test_ctrl #(
  parameter int CHAIN_LEN = 5,
  parameter int PI_W      = 2,
  parameter int PO_W      = 2,
  parameter int CNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  b01_scan_test_ctrl_if.slave pif,
  output logic                test_se,
  output logic                test_si,
  input  logic                test_so,
  output logic [PI_W-1:0]     core_pi,
  input  logic [PO_W-1:0]     core_po
);
  localparam int CW = $clog2(CHAIN_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_CAPTURE, S_WAIT, S_UNLOAD, S_REPORT
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [CHAIN_LEN-1:0] scan_q, scan_d, exp_q, exp_d, prev_exp_q, prev_exp_d;
  logic [PO_W-1:0]      exp_po_q, exp_po_d;
  logic [PI_W-1:0]      core_pi_q, core_pi_d;
  logic                 last_q, last_d, have_prev_q, have_prev_d;
  logic                 mis_q, mis_d, prev_po_mis_q, prev_po_mis_d;
  logic [CNT_W-1:0]     cur_idx_q, cur_idx_d, next_idx_q, next_idx_d, prev_idx_q, prev_idx_d;
  logic                 test_se_q, test_se_d, test_si_q, test_si_d;
  logic                 res_valid_q, res_valid_d, res_fail_q, res_fail_d, done_q, done_d;
  logic [CNT_W-1:0]     res_index_q, res_index_d, fail_count_q, fail_count_d;
  logic                 rdy, xfer, mis_nxt, cnt_end;

  assign rdy     = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign xfer    = pif.pat_valid && rdy;
  assign cnt_inc = cnt_q + CW'(1);
  assign cnt_end = (cnt_q == CW'(CHAIN_LEN - 1));
  // The final compare bit folds in here so the result can be registered on the same edge.
  assign mis_nxt = mis_q | (have_prev_q & (test_so ^ prev_exp_q[cnt_q]));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    scan_d        = scan_q;
    exp_d         = exp_q;
    exp_po_d      = exp_po_q;
    core_pi_d     = core_pi_q;
    last_d        = last_q;
    have_prev_d   = have_prev_q;
    mis_d         = mis_q;
    prev_exp_d    = prev_exp_q;
    prev_po_mis_d = prev_po_mis_q;
    cur_idx_d     = cur_idx_q;
    next_idx_d    = next_idx_q;
    prev_idx_d    = prev_idx_q;
    test_se_d     = test_se_q;
    test_si_d     = test_si_q;
    res_valid_d   = 1'b0;
    res_fail_d    = res_fail_q;
    res_index_d   = res_index_q;
    done_d        = 1'b0;
    fail_count_d  = fail_count_q;
    if (res_valid_q && res_fail_q && (fail_count_q != {CNT_W{1'b1}}))
      fail_count_d = fail_count_q + CNT_W'(1);

    case (state_q)
      S_IDLE, S_WAIT: begin
        if (xfer) begin
          scan_d    = pif.pat_scan;
          exp_d     = pif.pat_exp;
          exp_po_d  = pif.pat_exp_po;
          core_pi_d = pif.pat_pi;
          last_d    = pif.pat_last;
          test_se_d = 1'b1;
          test_si_d = pif.pat_scan[0];
          cnt_d     = '0;
          mis_d     = 1'b0;
          state_d   = S_SHIFT;
          if (state_q == S_IDLE) begin
            cur_idx_d    = '0;
            next_idx_d   = CNT_W'(1);
            have_prev_d  = 1'b0;
            fail_count_d = '0;
          end else begin
            cur_idx_d  = next_idx_q;
            next_idx_d = next_idx_q + CNT_W'(1);
          end
        end
      end
      S_SHIFT, S_UNLOAD: begin
        mis_d = mis_nxt;
        if (cnt_end) begin
          test_se_d   = 1'b0;
          test_si_d   = 1'b0;
          res_valid_d = have_prev_q;
          res_fail_d  = mis_nxt | prev_po_mis_q;
          res_index_d = prev_idx_q;
          done_d      = (state_q == S_UNLOAD);
          state_d     = (state_q == S_UNLOAD) ? S_REPORT : S_CAPTURE;
        end else begin
          cnt_d     = cnt_inc;
          test_si_d = (state_q == S_SHIFT) ? scan_q[cnt_inc] : 1'b0;
        end
      end
      S_CAPTURE: begin
        prev_po_mis_d = |(core_po ^ exp_po_q);
        prev_exp_d    = exp_q;
        prev_idx_d    = cur_idx_q;
        have_prev_d   = 1'b1;
        if (last_q) begin
          test_se_d = 1'b1;
          test_si_d = 1'b0;
          cnt_d     = '0;
          mis_d     = 1'b0;
          state_d   = S_UNLOAD;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      scan_q        <= '0;
      exp_q         <= '0;
      exp_po_q      <= '0;
      core_pi_q     <= '0;
      last_q        <= 1'b0;
      have_prev_q   <= 1'b0;
      mis_q         <= 1'b0;
      prev_exp_q    <= '0;
      prev_po_mis_q <= 1'b0;
      cur_idx_q     <= '0;
      next_idx_q    <= '0;
      prev_idx_q    <= '0;
      test_se_q     <= 1'b0;
      test_si_q     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_fail_q    <= 1'b0;
      res_index_q   <= '0;
      done_q        <= 1'b0;
      fail_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      scan_q        <= scan_d;
      exp_q         <= exp_d;
      exp_po_q      <= exp_po_d;
      core_pi_q     <= core_pi_d;
      last_q        <= last_d;
      have_prev_q   <= have_prev_d;
      mis_q         <= mis_d;
      prev_exp_q    <= prev_exp_d;
      prev_po_mis_q <= prev_po_mis_d;
      cur_idx_q     <= cur_idx_d;
      next_idx_q    <= next_idx_d;
      prev_idx_q    <= prev_idx_d;
      test_se_q     <= test_se_d;
      test_si_q     <= test_si_d;
      res_valid_q   <= res_valid_d;
      res_fail_q    <= res_fail_d;
      res_index_q   <= res_index_d;
      done_q        <= done_d;
      fail_count_q  <= fail_count_d;
    end
  end

  assign pif.pat_ready  = rdy;
  assign pif.res_valid  = res_valid_q;
  assign pif.res_fail   = res_fail_q;
  assign pif.res_index  = res_index_q;
  assign pif.fail_count = fail_count_q;
  assign pif.done       = done_q;
  assign test_se        = test_se_q;
  assign test_si        = test_si_q;
  assign core_pi        = core_pi_q;
endmodule

// File: tb/tb_b01_scan_test_ctrl.sv
// Bench for b01_scan_test_ctrl: behavioural scan core, expected results queued at send and popped on res_valid.
module tb_b01_scan_test_ctrl;
  localparam int CL    = 5;
  localparam int PI_W  = 2;
  localparam int PO_W  = 2;
  localparam int CNT_W = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            test_se, test_si, test_so;
  logic [PI_W-1:0] core_pi;
  logic [PO_W-1:0] core_po;

  always #5 clock = ~clock;

  b01_scan_test_ctrl_if #(.CHAIN_LEN(CL), .PI_W(PI_W), .PO_W(PO_W), .CNT_W(CNT_W)) pif ();

  b01_scan_test_ctrl #(.CHAIN_LEN(CL), .PI_W(PI_W), .PO_W(PO_W), .CNT_W(CNT_W)) u_dut (
    .clock   (clock),
    .reset   (reset),
    .pif     (pif),
    .test_se (test_se),
    .test_si (test_si),
    .test_so (test_so),
    .core_pi (core_pi),
    .core_po (core_po)
  );

  // Behavioural core: chain shifts toward test_so, captures every cycle scan enable is low.
  function automatic logic [CL-1:0] core_cap(input logic [CL-1:0] s, input logic [PI_W-1:0] pi);
    return {s[CL-2:0], s[CL-1]} ^ {{(CL-PI_W){1'b0}}, pi};
  endfunction

  function automatic logic [PO_W-1:0] core_out(input logic [CL-1:0] s, input logic [PI_W-1:0] pi);
    return {^s, s[CL-1] ^ pi[1] ^ pi[0]};
  endfunction

  logic [CL-1:0] chain = '0;
  always @(posedge clock) begin
    if (test_se) chain <= {test_si, chain[CL-1:1]};
    else         chain <= core_cap(chain, core_pi);
  end
  assign test_so = chain[0];
  assign core_po = core_out(chain, core_pi);

  typedef struct packed {
    logic [CNT_W-1:0] idx;
    logic             fail;
  } res_t;

  res_t             sb_q[$];
  res_t             mon_e;
  logic [CNT_W-1:0] exp_idx = '0;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               res_cyc = 0;
  int               n_res = 0;
  int               xfer_cyc = 0;
  int               prev_xfer = 0;
  int               n_before = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && pif.res_valid) begin
      n_res++;
      res_cyc = cyc;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL res_unexpected observed=res_valid index=%0d expected=no result", pif.res_index);
      end
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        chk("res_index", 32'(pif.res_index), 32'(mon_e.idx));
        chk("res_fail", 32'(pif.res_fail), 32'(mon_e.fail));
      end
    end
  end

  // Non-last patterns see two captures: the CAPTURE cycle and the single WAIT cycle.
  task automatic send(input logic [CL-1:0] scan, input logic [PI_W-1:0] pi,
                      input logic [CL-1:0] flip_exp, input logic [PO_W-1:0] flip_po,
                      input logic last, input bit expect_res);
    logic [CL-1:0] t;
    res_t          e;
    bit            got;
    t = core_cap(scan, pi);
    if (!last) t = core_cap(t, pi);
    @(negedge clock);
    pif.pat_valid  = 1'b1;
    pif.pat_scan   = scan;
    pif.pat_pi     = pi;
    pif.pat_exp    = t ^ flip_exp;
    pif.pat_exp_po = core_out(scan, pi) ^ flip_po;
    pif.pat_last   = last;
    if (expect_res) begin
      e.idx  = exp_idx;
      e.fail = (flip_exp != '0) || (flip_po != '0);
      sb_q.push_back(e);
      exp_idx = exp_idx + 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (pif.pat_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk("xfer_ready", 32'(got), 32'd1);
    prev_xfer = xfer_cyc;
    xfer_cyc  = cyc;
  endtask

  task automatic finish_session(input logic [CNT_W-1:0] exp_fc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clock);
      pif.pat_valid = 1'b0;
      if (pif.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_with_res", 32'(pif.res_valid), 32'd1);
    @(negedge clock);
    chk("done_pulse", 32'(pif.done), 32'd0);
    chk("fail_count", 32'(pif.fail_count), 32'(exp_fc));
  endtask

  initial begin
    pif.pat_valid  = 1'b0;
    pif.pat_scan   = '0;
    pif.pat_pi     = '0;
    pif.pat_exp    = '0;
    pif.pat_exp_po = '0;
    pif.pat_last   = 1'b0;
    #1 reset = 1'b1;
    #2;
    chk("rst_test_se", 32'(test_se), 32'd0);
    chk("rst_test_si", 32'(test_si), 32'd0);
    chk("rst_core_pi", 32'(core_pi), 32'd0);
    chk("rst_res_valid", 32'(pif.res_valid), 32'd0);
    chk("rst_fail_count", 32'(pif.fail_count), 32'd0);
    chk("rst_done", 32'(pif.done), 32'd0);
    chk("rst_ready", 32'(pif.pat_ready), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Single passing pattern: minimum latency path through UNLOAD/REPORT.
    exp_idx = '0;
    send(5'b10110, 2'b01, '0, '0, 1'b1, 1'b1);
    @(negedge clock);
    chk("shift_se", 32'(test_se), 32'd1);
    chk("shift_si0", 32'(test_si), 32'd0);
    chk("shift_pi", 32'(core_pi), 32'd1);
    finish_session(2'd0);
    chk("latency", 32'(res_cyc - xfer_cyc), 32'd12);

    // Three back-to-back patterns, pattern 1 has exp bit 3 flipped.
    exp_idx = '0;
    send(5'b01101, 2'b10, '0, '0, 1'b0, 1'b1);
    send(5'b11001, 2'b11, 5'b01000, '0, 1'b0, 1'b1);
    chk("gap01", 32'(xfer_cyc - prev_xfer), 32'd7);
    send(5'b00111, 2'b00, '0, '0, 1'b1, 1'b1);
    chk("gap12", 32'(xfer_cyc - prev_xfer), 32'd7);
    finish_session(2'd1);
    repeat (3) @(negedge clock);
    chk("fc_hold", 32'(pif.fail_count), 32'd1);

    // PO mismatch only on pattern 0.
    exp_idx = '0;
    send(5'b10011, 2'b01, '0, 2'b01, 1'b0, 1'b1);
    @(negedge clock);
    chk("fc_cleared", 32'(pif.fail_count), 32'd0);
    send(5'b01010, 2'b10, '0, '0, 1'b1, 1'b1);
    finish_session(2'd1);

    // Reset in the middle of SHIFT (cnt==2) aborts without a result.
    send(5'b11100, 2'b11, '0, '0, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    chk("se_mid_shift", 32'(test_se), 32'd1);
    pif.pat_valid = 1'b0;
    n_before = n_res;
    #2 reset = 1'b1;
    #1;
    chk("se_on_reset", 32'(test_se), 32'd0);
    chk("ready_on_reset", 32'(pif.pat_ready), 32'd1);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("no_res_after_reset", 32'(n_res), 32'(n_before));

    exp_idx = '0;
    send(5'b00101, 2'b10, '0, '0, 1'b1, 1'b1);
    finish_session(2'd0);

    // Five failing patterns: index wraps 0,1,2,3,0 and fail_count saturates.
    exp_idx = '0;
    for (int j = 0; j < 5; j++) begin
      send(CL'($urandom), PI_W'($urandom), 5'b00001, '0, (j == 4), 1'b1);
    end
    finish_session(2'd3);

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
